// File: rtl/aes_req_arbiter_if.sv
// Bundle of requester, AES-core and response signals shared by the arbiter and its environment.
// slave = arbiter side, master = requesters/core/response-consumer side.
interface aes_req_arbiter_if;
    logic         req0_valid;
    logic         req1_valid;
    logic         req0_ready;
    logic         req1_ready;
    logic [127:0] req0_plain;
    logic [127:0] req0_key;
    logic [127:0] req1_plain;
    logic [127:0] req1_key;

    logic         core_start;
    logic         core_new_pair;
    logic [127:0] core_plain;
    logic [127:0] core_key;
    logic [127:0] core_cipher;
    logic         core_done;

    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [127:0] rsp_cipher;
    logic         rsp_err;

    logic         busy;

    modport slave (
        input  req0_valid, req1_valid, req0_plain, req0_key, req1_plain, req1_key,
        input  core_cipher, core_done, rsp_ready,
        output req0_ready, req1_ready, core_start, core_new_pair, core_plain, core_key,
        output rsp_valid, rsp_id, rsp_cipher, rsp_err, busy
    );

    modport master (
        output req0_valid, req1_valid, req0_plain, req0_key, req1_plain, req1_key,
        output core_cipher, core_done, rsp_ready,
        input  req0_ready, req1_ready, core_start, core_new_pair, core_plain, core_key,
        input  rsp_valid, rsp_id, rsp_cipher, rsp_err, busy
    );
endinterface

// File: rtl/aes_req_arbiter.sv
// Round-robin arbiter of two requesters onto one AES core; optional WAIT timeout under AES_ARB_TIMEOUT_EN.
// Latency: accept -> LAUNCH -> WAIT (until qualified core_done) -> registered rsp_valid.
// Backpressure: one operation in flight; requesters stall until the response handshake completes.
module aes_req_arbiter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rst,
    aes_req_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

    state_t       r_state;
    state_t       w_next;
    logic         r_rr_last;
    logic         r_first_op;
    logic         r_seen_low;
    logic         r_rsp_valid;
    logic         r_rsp_id;
    logic [127:0] r_core_plain;
    logic [127:0] r_core_key;
    logic [127:0] r_rsp_cipher;

    logic         w_win;
    logic         w_accept;
    logic         w_done_q;
    logic         w_tmo;
    logic         w_start;
    logic         w_new_pair;

    // On a tie the requester not granted last wins; otherwise the lone valid one.
    assign w_win    = (bus.req0_valid && bus.req1_valid) ? ~r_rr_last : bus.req1_valid;
    assign w_accept = (r_state == IDLE) && (bus.req0_valid || bus.req1_valid);
    // A done level still high from the previous operation must fall before it counts.
    assign w_done_q = (r_state == WAIT) && bus.core_done && r_seen_low;

`ifdef AES_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_tmo_cnt;
    logic          r_rsp_err;

    assign w_tmo = (r_state == WAIT) && !w_done_q && (r_tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo_cnt <= '0;
            r_rsp_err <= 1'b0;
        end else begin
            if (r_state == LAUNCH) begin
                r_tmo_cnt <= '0;
            end else if (r_state == WAIT) begin
                r_tmo_cnt <= r_tmo_cnt + CW'(1);
            end
            if (w_done_q) begin
                r_rsp_err <= 1'b0;
            end else if (w_tmo) begin
                r_rsp_err <= 1'b1;
            end
        end
    end

    assign bus.rsp_err = r_rsp_err;
`else
    // Constant false: without the counter WAIT only leaves on a qualified done.
    assign w_tmo       = (TIMEOUT_CYCLES < 0);
    assign bus.rsp_err = 1'b0;
`endif

    always_comb begin
        w_next     = r_state;
        w_start    = 1'b0;
        w_new_pair = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) w_next = LAUNCH;
            end
            LAUNCH: begin
                w_start    = r_first_op;
                w_new_pair = ~r_first_op;
                w_next     = WAIT;
            end
            WAIT: begin
                if (w_done_q || w_tmo) w_next = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_last    <= 1'b1;
            r_first_op   <= 1'b1;
            r_seen_low   <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_core_plain <= '0;
            r_core_key   <= '0;
            r_rsp_cipher <= '0;
        end else begin
            if (w_accept) begin
                r_core_plain <= w_win ? bus.req1_plain : bus.req0_plain;
                r_core_key   <= w_win ? bus.req1_key   : bus.req0_key;
                r_rsp_id     <= w_win;
                r_rr_last    <= w_win;
            end
            if (r_state == LAUNCH) begin
                r_first_op <= 1'b0;
                r_seen_low <= ~bus.core_done;
            end else if ((r_state == WAIT) && !bus.core_done) begin
                r_seen_low <= 1'b1;
            end
            if (w_done_q) begin
                r_rsp_cipher <= bus.core_cipher;
            end else if (w_tmo) begin
                r_rsp_cipher <= '0;
            end
            if ((r_state == WAIT) && (w_next == RESP)) begin
                r_rsp_valid <= 1'b1;
            end else if ((r_state == RESP) && bus.rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign bus.req0_ready    = w_accept && !w_win;
    assign bus.req1_ready    = w_accept && w_win;
    assign bus.core_start    = w_start;
    assign bus.core_new_pair = w_new_pair;
    assign bus.core_plain    = r_core_plain;
    assign bus.core_key      = r_core_key;
    assign bus.rsp_valid     = r_rsp_valid;
    assign bus.rsp_id        = r_rsp_id;
    assign bus.rsp_cipher    = r_rsp_cipher;
    assign bus.busy          = (r_state != IDLE);

endmodule
